// File: rtl/otter_rob.sv
// rtl/otter_rob.sv - in-order-retire reorder buffer with multi-lane dispatch/commit and precise flush
module otter_rob #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2,
  parameter int XLEN  = 32,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [WIDTH-1:0]        disp_valid,
  input  logic [WIDTH*5-1:0]      disp_rd_addr,
  input  logic [WIDTH-1:0]        disp_rd_used,
  input  logic [WIDTH*XLEN-1:0]   disp_pc,
  output logic                    disp_ready,
  output logic [WIDTH*TAG_W-1:0]  disp_tag,
  input  logic                    cmp_valid,
  input  logic [TAG_W-1:0]        cmp_tag,
  input  logic [XLEN-1:0]         cmp_data,
  input  logic                    cmp_mispredict,
  input  logic [XLEN-1:0]         cmp_target,
  output logic [WIDTH-1:0]        commit_valid,
  output logic [WIDTH-1:0]        commit_we,
  output logic [WIDTH*5-1:0]      commit_rd_addr,
  output logic [WIDTH*XLEN-1:0]   commit_data,
  output logic [WIDTH*XLEN-1:0]   commit_pc,
  output logic                    flush,
  output logic [XLEN-1:0]         flush_pc,
  output logic [TAG_W:0]          count
);

  localparam logic [TAG_W:0] MAX_FILL = (TAG_W+1)'(DEPTH - WIDTH);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] r_done;
  logic [DEPTH-1:0] r_mis;
  logic [DEPTH-1:0] r_rd_used;
  logic [4:0]       r_rd_addr [DEPTH];
  logic [XLEN-1:0]  r_pc      [DEPTH];
  logic [XLEN-1:0]  r_data    [DEPTH];
  logic [XLEN-1:0]  r_target  [DEPTH];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  logic [TAG_W-1:0] w_lane_idx [WIDTH];
  logic [TAG_W:0]   w_retire_cnt;
  logic [TAG_W:0]   w_disp_cnt;
  logic             w_chain;
  logic             w_disp_fire;
  logic             w_cmp_fire;

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_lane
      assign w_lane_idx[g] = r_head + TAG_W'(g);
      assign disp_tag[g*TAG_W +: TAG_W] = r_tail + TAG_W'(g);
    end
  endgenerate

  assign count       = r_count;
  // Space freed by this cycle's retirement is deliberately not reused until next cycle.
  assign disp_ready  = (r_count <= MAX_FILL);
  assign w_disp_fire = disp_ready & disp_valid[0] & ~flush;
  assign w_cmp_fire  = cmp_valid & r_busy[cmp_tag] & ~flush;

  always_comb begin
    commit_valid   = '0;
    commit_we      = '0;
    commit_rd_addr = '0;
    commit_data    = '0;
    commit_pc      = '0;
    flush          = 1'b0;
    flush_pc       = '0;
    w_retire_cnt   = '0;
    w_chain        = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      commit_rd_addr[i*5 +: 5]  = r_rd_addr[w_lane_idx[i]];
      commit_data[i*XLEN +: XLEN] = r_data[w_lane_idx[i]];
      commit_pc[i*XLEN +: XLEN]   = r_pc[w_lane_idx[i]];
      if (w_chain && r_busy[w_lane_idx[i]] && r_done[w_lane_idx[i]]) begin
        commit_valid[i] = 1'b1;
        commit_we[i]    = r_rd_used[w_lane_idx[i]] && (r_rd_addr[w_lane_idx[i]] != 5'd0);
        w_retire_cnt    = w_retire_cnt + (TAG_W+1)'(1);
        // A mispredicted entry retires itself but blocks every younger lane.
        if (r_mis[w_lane_idx[i]]) begin
          flush    = 1'b1;
          flush_pc = r_target[w_lane_idx[i]];
          w_chain  = 1'b0;
        end
      end else begin
        w_chain = 1'b0;
      end
    end
  end

  always_comb begin
    w_disp_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_disp_fire && disp_valid[i]) w_disp_cnt = w_disp_cnt + (TAG_W+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_busy  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_busy  <= '0;
      r_head  <= r_head + TAG_W'(w_retire_cnt);
      r_tail  <= r_head + TAG_W'(w_retire_cnt);
      r_count <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (commit_valid[i]) r_busy[w_lane_idx[i]] <= 1'b0;
      end
      if (w_cmp_fire) begin
        r_done[cmp_tag]   <= 1'b1;
        r_mis[cmp_tag]    <= cmp_mispredict;
        r_data[cmp_tag]   <= cmp_data;
        r_target[cmp_tag] <= cmp_target;
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (w_disp_fire && disp_valid[i]) begin
          r_busy[r_tail + TAG_W'(i)]    <= 1'b1;
          r_done[r_tail + TAG_W'(i)]    <= 1'b0;
          r_mis[r_tail + TAG_W'(i)]     <= 1'b0;
          r_rd_used[r_tail + TAG_W'(i)] <= disp_rd_used[i];
          r_rd_addr[r_tail + TAG_W'(i)] <= disp_rd_addr[i*5 +: 5];
          r_pc[r_tail + TAG_W'(i)]      <= disp_pc[i*XLEN +: XLEN];
        end
      end
      r_head  <= r_head + TAG_W'(w_retire_cnt);
      r_tail  <= r_tail + TAG_W'(w_disp_cnt);
      r_count <= r_count + w_disp_cnt - w_retire_cnt;
    end
  end

endmodule

// File: tb/tb_otter_rob.sv
// tb/tb_otter_rob.sv - otter_rob bench: queue model compared every cycle, directed and random stimulus
module tb_otter_rob;
  localparam int DEPTH = 8;
  localparam int WIDTH = 2;
  localparam int XLEN  = 32;
  localparam int TAG_W = 3;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [1:0]  disp_valid;
  logic [9:0]  disp_rd_addr;
  logic [1:0]  disp_rd_used;
  logic [63:0] disp_pc;
  logic        disp_ready;
  logic [5:0]  disp_tag;
  logic        cmp_valid;
  logic [2:0]  cmp_tag;
  logic [31:0] cmp_data;
  logic        cmp_mispredict;
  logic [31:0] cmp_target;
  logic [1:0]  commit_valid;
  logic [1:0]  commit_we;
  logic [9:0]  commit_rd_addr;
  logic [63:0] commit_data;
  logic [63:0] commit_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic [3:0]  count;

  otter_rob #(.DEPTH(DEPTH), .WIDTH(WIDTH), .XLEN(XLEN)) dut (
    .CLK(CLK), .RESET(RESET),
    .disp_valid(disp_valid), .disp_rd_addr(disp_rd_addr), .disp_rd_used(disp_rd_used),
    .disp_pc(disp_pc), .disp_ready(disp_ready), .disp_tag(disp_tag),
    .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_data(cmp_data),
    .cmp_mispredict(cmp_mispredict), .cmp_target(cmp_target),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd_addr(commit_rd_addr),
    .commit_data(commit_data), .commit_pc(commit_pc),
    .flush(flush), .flush_pc(flush_pc), .count(count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  rd;
    logic        used;
    logic [31:0] pc;
    logic        done;
    logic        mis;
    logic [31:0] data;
    logic [31:0] target;
  } ent_t;

  // Program-ordered list of in-flight instructions; q[0] is the oldest, tagged m_head.
  ent_t q[$];
  int   m_head = 0;
  bit   model_valid = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [1:0]  e_valid, e_we;
  logic        e_fl;
  logic [31:0] e_fpc;
  logic [5:0]  e_tag;
  int          n_ret, sz, p;
  bit          stop;
  ent_t        ne;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    sz = q.size();
    e_valid = '0; e_we = '0; e_fl = 0; e_fpc = '0; n_ret = 0; stop = 0;
    for (int i = 0; i < 2; i++) begin
      if (!stop && i < sz && q[i].done) begin
        e_valid[i] = 1'b1;
        e_we[i] = q[i].used && (q[i].rd != 5'd0);
        n_ret++;
        if (q[i].mis) begin e_fl = 1; e_fpc = q[i].target; stop = 1; end
      end else stop = 1;
    end
    e_tag[2:0] = 3'((m_head + sz) % 8);
    e_tag[5:3] = 3'((m_head + sz + 1) % 8);
    if (model_valid) begin
      chk("count", 64'(count), 64'(sz));
      chk("disp_ready", 64'(disp_ready), 64'(8 - sz >= 2));
      chk("disp_tag", 64'(disp_tag), 64'(e_tag));
      chk("commit_valid", 64'(commit_valid), 64'(e_valid));
      chk("commit_we", 64'(commit_we), 64'(e_we));
      chk("flush", 64'(flush), 64'(e_fl));
      chk("flush_pc", 64'(flush_pc), 64'(e_fpc));
      for (int i = 0; i < 2; i++) begin
        if (e_valid[i]) begin
          chk($sformatf("commit_rd%0d", i), 64'(commit_rd_addr[i*5 +: 5]), 64'(q[i].rd));
          chk($sformatf("commit_data%0d", i), 64'(commit_data[i*32 +: 32]), 64'(q[i].data));
          chk($sformatf("commit_pc%0d", i), 64'(commit_pc[i*32 +: 32]), 64'(q[i].pc));
        end
      end
    end
    if (RESET) begin
      q.delete(); m_head = 0; model_valid = 1;
    end else if (model_valid) begin
      if (e_fl) begin
        m_head = (m_head + n_ret) % 8;
        q.delete();
      end else begin
        if (cmp_valid) begin
          p = (int'(cmp_tag) - m_head + 8) % 8;
          if (p < sz) begin
            q[p].done = 1; q[p].mis = cmp_mispredict;
            q[p].data = cmp_data; q[p].target = cmp_target;
          end
        end
        for (int i = 0; i < n_ret; i++) void'(q.pop_front());
        m_head = (m_head + n_ret) % 8;
        if (8 - sz >= 2 && disp_valid[0]) begin
          for (int i = 0; i < 2; i++) begin
            if (disp_valid[i]) begin
              ne.rd = disp_rd_addr[i*5 +: 5]; ne.used = disp_rd_used[i];
              ne.pc = disp_pc[i*32 +: 32]; ne.done = 0; ne.mis = 0;
              ne.data = '0; ne.target = '0;
              q.push_back(ne);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RESET = 0; disp_valid = '0; disp_rd_addr = '0; disp_rd_used = '0; disp_pc = '0;
    cmp_valid = 0; cmp_tag = '0; cmp_data = '0; cmp_mispredict = 0; cmp_target = '0;
  endtask

  task automatic disp(input logic [1:0] v, input logic [4:0] rd0, input logic [4:0] rd1,
                      input logic [31:0] pc0);
    disp_valid = v; disp_rd_addr = {rd1, rd0}; disp_rd_used = 2'b11;
    disp_pc = {pc0 + 32'd4, pc0};
  endtask

  task automatic cmp(input logic [2:0] t, input logic [31:0] d, input logic m, input logic [31:0] tg);
    cmp_valid = 1; cmp_tag = t; cmp_data = d; cmp_mispredict = m; cmp_target = tg;
  endtask

  initial begin
    idle();
    RESET = 1;
    tick(); tick();
    idle();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(disp_ready), 64'd1);
    chk("rst_tag", 64'(disp_tag), 64'h08);
    chk("rst_commit", 64'(commit_valid), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);

    // fill
    disp(2'b11, 5'd1, 5'd2, 32'h0); tick();
    chk("fill_tag1", 64'(disp_tag), 64'h1A);
    disp(2'b11, 5'd3, 5'd4, 32'h8); tick();
    chk("fill_tag2", 64'(disp_tag), 64'h2C);
    disp(2'b11, 5'd5, 5'd6, 32'h10); tick();
    chk("fill_cnt6", 64'(count), 64'd6);
    chk("fill_rdy6", 64'(disp_ready), 64'd1);
    chk("fill_tag3", 64'(disp_tag), 64'h3E);
    disp(2'b11, 5'd7, 5'd8, 32'h18); tick();
    chk("fill_cnt8", 64'(count), 64'd8);
    chk("fill_rdy8", 64'(disp_ready), 64'd0);
    disp(2'b11, 5'd9, 5'd10, 32'h20); tick();
    chk("fill_drop", 64'(count), 64'd8);
    idle(); RESET = 1; tick(); idle();

    // out-of-order completion
    disp(2'b11, 5'd5, 5'd6, 32'h40); tick();
    disp(2'b01, 5'd7, 5'd0, 32'h48); tick();
    idle(); cmp(3'd2, 32'hC, 0, 0); tick();
    chk("ooo_wait2", 64'(commit_valid), 64'd0);
    idle(); cmp(3'd1, 32'hB, 0, 0); tick();
    chk("ooo_wait1", 64'(commit_valid), 64'd0);
    idle(); cmp(3'd0, 32'hA, 0, 0); tick();
    chk("ooo_cv01", 64'(commit_valid), 64'd3);
    chk("ooo_we01", 64'(commit_we), 64'd3);
    chk("ooo_rd01", 64'(commit_rd_addr), 64'({5'd6, 5'd5}));
    chk("ooo_data01", commit_data, 64'h0000000B_0000000A);
    idle(); tick();
    chk("ooo_cv2", 64'(commit_valid), 64'd1);
    chk("ooo_rd2", 64'(commit_rd_addr[4:0]), 64'd7);
    chk("ooo_data2", 64'(commit_data[31:0]), 64'hC);
    idle(); tick();
    chk("ooo_empty", 64'(count), 64'd0);

    // mispredict
    RESET = 1; tick(); idle();
    disp(2'b11, 5'd1, 5'd2, 32'h80); tick();
    disp(2'b11, 5'd3, 5'd4, 32'h88); tick();
    idle(); cmp(3'd1, 32'h20, 1, 32'h100); tick();
    idle(); cmp(3'd0, 32'h10, 0, 0); tick();
    chk("mis_cv", 64'(commit_valid), 64'd3);
    chk("mis_flush", 64'(flush), 64'd1);
    chk("mis_fpc", 64'(flush_pc), 64'h100);
    idle(); cmp(3'd2, 32'h30, 0, 0); disp(2'b11, 5'd9, 5'd9, 32'h200); tick();
    chk("mis_cnt", 64'(count), 64'd0);
    chk("mis_flush_off", 64'(flush), 64'd0);
    chk("mis_tag", 64'(disp_tag), 64'h1A);
    idle(); cmp(3'd3, 32'h40, 0, 0); tick();
    chk("mis_ignored", 64'(commit_valid), 64'd0);

    // wrap-around, head starts at tag 2
    for (int i = 0; i < 20; i++) begin
      idle(); disp(2'b01, 5'((i % 31) + 1), 5'd0, 32'h1000 + 32'(4 * i)); tick();
      idle(); cmp(3'((2 + i) % 8), 32'(i), 0, 0); tick();
      chk("wrap_cv", 64'(commit_valid), 64'd1);
      chk("wrap_pc", 64'(commit_pc[31:0]), 64'(32'h1000 + 32'(4 * i)));
    end
    idle(); tick();

    // x0 destination, head at tag 6
    disp(2'b01, 5'd0, 5'd0, 32'h3000); tick();
    idle(); cmp(3'd6, 32'h55, 0, 0); tick();
    chk("x0_cv", 64'(commit_valid), 64'd1);
    chk("x0_we", 64'(commit_we), 64'd0);
    idle(); tick();

    // reset with entries in flight
    disp(2'b11, 5'd1, 5'd2, 32'h4000); tick();
    disp(2'b11, 5'd3, 5'd4, 32'h4008); tick();
    disp(2'b01, 5'd5, 5'd0, 32'h4010); tick();
    idle(); tick();
    chk("inflight5", 64'(count), 64'd5);
    RESET = 1; tick(); idle();
    chk("rst5_cnt", 64'(count), 64'd0);
    chk("rst5_cv", 64'(commit_valid), 64'd0);
    tick();
    chk("rst5_cv_next", 64'(commit_valid), 64'd0);

    // random
    for (int c = 0; c < 3000; c++) begin
      idle();
      disp_valid[0] = ($urandom % 3) != 0;
      disp_valid[1] = disp_valid[0] & 1'($urandom);
      disp_rd_addr = 10'($urandom);
      disp_rd_used = 2'($urandom);
      disp_pc = {$urandom, $urandom};
      if (($urandom % 4) != 0 && q.size() > 0) begin
        cmp_valid = 1;
        cmp_tag = 3'((m_head + int'($urandom % q.size())) % 8);
      end else if (($urandom % 8) == 0) begin
        cmp_valid = 1;
        cmp_tag = 3'($urandom);
      end
      cmp_data = $urandom;
      cmp_mispredict = ($urandom % 16) == 0;
      cmp_target = $urandom;
      RESET = ($urandom % 300) == 0;
      tick();
    end

    idle(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
